// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-memory fetch controller.
// Takes the PC from the fetch stage, issues one read per PC over a valid/ready
// request channel, waits for the response, and hands the instruction to decode
// with a valid/ready handshake.
// It also holds the PC through pc_stall, flushes on redirect, and flags
// misaligned fetches.
// Optional build macro FETCH_TIMEOUT_EN adds a response watchdog.
// That watchdog faults with cause 2'b10 after TIMEOUT_CYCLES silent WAIT cycles.
module imem_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        redirect,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_stall,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;
    localparam logic [7:0] WDOG_LAST       = 8'(TIMEOUT_CYCLES - 1);
`endif

    // Reject a watchdog limit the 8-bit counter cannot represent.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("imem_fetch_ctrl: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        fetch_fault_q;
    logic [1:0]  fault_cause_q;
    logic        drop_q;        // in-flight response must be discarded
`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  wdog_q;
`endif

    logic addr_aligned;
    logic handshake;

    assign addr_aligned = (address[1:0] == 2'b00);
    assign handshake    = instr_valid_q & instr_ready;

    // Request channel passes the live PC through while in REQ, so a redirect
    // that lands in REQ is picked up without any extra bookkeeping.
    assign imem_req_valid = (state_q == ST_REQ) && addr_aligned;
    assign imem_req_addr  = (state_q == ST_REQ) ? address : 32'h0;

    // The PC may advance only on the decode handshake edge.
    assign pc_stall = reset | ~handshake;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fault_cause = fault_cause_q;

    // Fetch FSM with registered decode-side and fault outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= 32'h0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            drop_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog_q        <= 8'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                end

                ST_REQ: begin
                    if (!addr_aligned) begin
                        state_q       <= ST_FAULT;
                        fetch_fault_q <= 1'b1;
                        fault_cause_q <= CAUSE_MISALIGN;
                    end else if (imem_req_ready) begin
                        pc_q    <= address;
                        state_q <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wdog_q  <= 8'h0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q || redirect) begin
                            // Response belongs to a flushed PC: throw it away.
                            drop_q  <= 1'b0;
                            state_q <= ST_REQ;
                        end else begin
                            instr_q       <= imem_rsp_data;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= ST_HOLD;
                        end
                    end else begin
                        if (redirect) begin
                            drop_q <= 1'b1;
                        end
`ifdef FETCH_TIMEOUT_EN
                        // Watchdog keeps running even while a drop is pending.
                        if (wdog_q == WDOG_LAST) begin
                            state_q       <= ST_FAULT;
                            fetch_fault_q <= 1'b1;
                            fault_cause_q <= CAUSE_TIMEOUT;
                            drop_q        <= 1'b0;
                        end else begin
                            wdog_q <= wdog_q + 8'd1;
                        end
`endif
                    end
                end

                ST_HOLD: begin
                    // A handshake takes priority over a simultaneous redirect.
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_REQ;
                    end else if (redirect) begin
                        instr_valid_q <= 1'b0;
                        instr_q       <= NOP_INSTR;
                        state_q       <= ST_REQ;
                    end
                end

                ST_FAULT: begin
                    if (redirect) begin
                        fetch_fault_q <= 1'b0;
                        fault_cause_q <= CAUSE_NONE;
                        state_q       <= ST_REQ;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a cycle table for the main flow, then
// hand-written sequences for the stall, flush and watchdog corner cases.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_stall;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_stall       (pc_stall),
        .fetch_fault    (fetch_fault),
        .fault_cause    (fault_cause)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        redir;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        irdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_iv;
        logic        e_stall;
        logic        e_fault;
        logic [1:0]  e_cause;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        string t;
        reset          = v.rst;
        address        = v.addr;
        redirect       = v.redir;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rspv;
        imem_rsp_data  = v.rspd;
        instr_ready    = v.irdy;
        settle();
        t = $sformatf("row%0d", idx);
        check({t, ".req_valid"},   32'(imem_req_valid), 32'(v.e_rv));
        check({t, ".req_addr"},    imem_req_addr,       v.e_ra);
        check({t, ".instr"},       instr,               v.e_instr);
        check({t, ".instr_pc"},    instr_pc,            v.e_pc);
        check({t, ".instr_valid"}, 32'(instr_valid),    32'(v.e_iv));
        check({t, ".pc_stall"},    32'(pc_stall),       32'(v.e_stall));
        check({t, ".fetch_fault"}, 32'(fetch_fault),    32'(v.e_fault));
        check({t, ".fault_cause"}, 32'(fault_cause),    32'(v.e_cause));
        tick();
    endtask

    initial begin
        //          rst addr          rd rdy rv rspd          irdy | rv ra           instr         pc            iv st ft cause
        vecs[0]  = '{1, 32'h0,        0, 1, 0, 32'h0,         1,     0, 32'h0,       NOP,          32'h0,        0, 1, 0, 2'd0};
        vecs[1]  = '{0, 32'h0,        0, 1, 0, 32'h0,         1,     0, 32'h0,       NOP,          32'h0,        0, 1, 0, 2'd0};
        vecs[2]  = '{0, 32'h0,        0, 1, 0, 32'h0,         1,     1, 32'h0,       NOP,          32'h0,        0, 1, 0, 2'd0};
        vecs[3]  = '{0, 32'h0,        0, 1, 1, 32'h0050_0093, 1,     0, 32'h0,       NOP,          32'h0,        0, 1, 0, 2'd0};
        vecs[4]  = '{0, 32'h0,        0, 1, 0, 32'h0,         1,     0, 32'h0,       32'h0050_0093, 32'h0,       1, 0, 0, 2'd0};
        vecs[5]  = '{0, 32'h4,        0, 1, 0, 32'h0,         1,     1, 32'h4,       32'h0050_0093, 32'h0,       0, 1, 0, 2'd0};
        vecs[6]  = '{0, 32'h4,        0, 1, 1, 32'h00A0_0113, 1,     0, 32'h0,       32'h0050_0093, 32'h0,       0, 1, 0, 2'd0};
        vecs[7]  = '{0, 32'h4,        0, 1, 0, 32'h0,         0,     0, 32'h0,       32'h00A0_0113, 32'h4,       1, 1, 0, 2'd0};
        vecs[8]  = '{0, 32'h4,        0, 1, 0, 32'h0,         1,     0, 32'h0,       32'h00A0_0113, 32'h4,       1, 0, 0, 2'd0};
        vecs[9]  = '{0, 32'h102,      0, 1, 0, 32'h0,         1,     0, 32'h102,     32'h00A0_0113, 32'h4,       0, 1, 0, 2'd0};
        vecs[10] = '{0, 32'h102,      0, 1, 1, 32'hBAD0_BAD0, 1,     0, 32'h0,       32'h00A0_0113, 32'h4,       0, 1, 1, 2'd1};
        vecs[11] = '{0, 32'h104,      1, 1, 0, 32'h0,         1,     0, 32'h0,       32'h00A0_0113, 32'h4,       0, 1, 1, 2'd1};
        vecs[12] = '{0, 32'h104,      0, 1, 0, 32'h0,         1,     1, 32'h104,     32'h00A0_0113, 32'h4,       0, 1, 0, 2'd0};
        vecs[13] = '{0, 32'h104,      0, 1, 1, 32'h0000_0033, 0,     0, 32'h0,       32'h00A0_0113, 32'h4,       0, 1, 0, 2'd0};
        vecs[14] = '{0, 32'h104,      1, 1, 0, 32'h0,         0,     0, 32'h0,       32'h0000_0033, 32'h104,     1, 1, 0, 2'd0};
        vecs[15] = '{0, 32'h200,      0, 0, 0, 32'h0,         0,     1, 32'h200,     NOP,          32'h104,      0, 1, 0, 2'd0};
        vecs[16] = '{1, 32'h200,      0, 0, 0, 32'h0,         0,     1, 32'h200,     NOP,          32'h104,      0, 1, 0, 2'd0};
        vecs[17] = '{0, 32'h200,      0, 0, 0, 32'h0,         0,     0, 32'h0,       NOP,          32'h0,        0, 1, 0, 2'd0};

        // Bring the DUT out of its power-up unknown state.
        reset          = 1'b1;
        address        = 32'h0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        tick();
        tick();

        for (int i = 0; i < NVEC; i++) begin
            apply_row(i, vecs[i]);
        end

        // Now in REQ. Memory holds off the request for 3 cycles, then answers
        // 5 cycles after acceptance.
        address        = 32'h8;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stallreq.req_valid", 32'(imem_req_valid), 32'h1);
            check("stallreq.req_addr",  imem_req_addr,       32'h8);
            check("stallreq.pc_stall",  32'(pc_stall),       32'h1);
            tick();
        end
        imem_req_ready = 1'b1;
        settle();
        check("accept.req_valid", 32'(imem_req_valid), 32'h1);
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("slowrsp.instr_valid", 32'(instr_valid),    32'h0);
            check("slowrsp.pc_stall",    32'(pc_stall),       32'h1);
            check("slowrsp.req_valid",   32'(imem_req_valid), 32'h0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        settle();
        check("rspcycle.instr_valid", 32'(instr_valid), 32'h0);
        tick();
        imem_rsp_valid = 1'b0;

        // Decode stalls for 4 cycles, accepts on the 5th.
        for (int i = 0; i < 4; i++) begin
            settle();
            check("hold.instr",       instr,             32'h1234_5678);
            check("hold.instr_pc",    instr_pc,          32'h8);
            check("hold.instr_valid", 32'(instr_valid),  32'h1);
            check("hold.pc_stall",    32'(pc_stall),     32'h1);
            tick();
        end
        instr_ready = 1'b1;
        settle();
        check("release.pc_stall", 32'(pc_stall), 32'h0);
        tick();
        settle();
        check("afterhs.instr_valid", 32'(instr_valid), 32'h0);
        check("afterhs.pc_stall",    32'(pc_stall),    32'h1);

        // Redirect while waiting: the late response must be discarded.
        address        = 32'hC;
        imem_req_ready = 1'b1;
        settle();
        check("flush.req_addr", imem_req_addr, 32'hC);
        tick();
        redirect = 1'b1;
        tick();
        redirect       = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        address        = 32'h100;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        check("flush.instr_valid", 32'(instr_valid),    32'h0);
        check("flush.instr",       instr,               32'h1234_5678);
        check("flush.req_valid",   32'(imem_req_valid), 32'h1);
        check("flush.req_addr2",   imem_req_addr,       32'h100);
        tick();

        // Redirect and response in the same WAIT cycle: response discarded.
        redirect       = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0BAD;
        tick();
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        settle();
        check("samecyc.instr_valid", 32'(instr_valid),    32'h0);
        check("samecyc.req_valid",   32'(imem_req_valid), 32'h1);
        check("samecyc.req_addr",    imem_req_addr,       32'h100);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        check("refetch.instr_valid", 32'(instr_valid), 32'h1);
        check("refetch.instr",       instr,            32'h1111_1111);
        check("refetch.instr_pc",    instr_pc,         32'h100);
        check("refetch.pc_stall",    32'(pc_stall),    32'h0);
        tick();

        // Response watchdog behaviour.
        address        = 32'h20;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            settle();
            check("wdog.fetch_fault", 32'(fetch_fault), 32'h0);
            check("wdog.instr_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        settle();
        check("timeout.fetch_fault", 32'(fetch_fault),    32'h1);
        check("timeout.fault_cause", 32'(fault_cause),    32'h2);
        check("timeout.req_valid",   32'(imem_req_valid), 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0055;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        check("late.fetch_fault", 32'(fetch_fault), 32'h1);
        check("late.fault_cause", 32'(fault_cause), 32'h2);
        check("late.instr_valid", 32'(instr_valid), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rst2.fetch_fault", 32'(fetch_fault),    32'h0);
        check("rst2.fault_cause", 32'(fault_cause),    32'h0);
        check("rst2.instr",       instr,               NOP);
        check("rst2.instr_pc",    instr_pc,            32'h0);
        check("rst2.instr_valid", 32'(instr_valid),    32'h0);
        check("rst2.req_valid",   32'(imem_req_valid), 32'h0);
        tick();
        // Response on the limit cycle wins over the timeout.
        address        = 32'h24;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        repeat (7) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0077;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        check("limitwin.fetch_fault", 32'(fetch_fault), 32'h0);
        check("limitwin.instr_valid", 32'(instr_valid), 32'h1);
        check("limitwin.instr",       instr,            32'h0000_0077);
        check("limitwin.instr_pc",    instr_pc,         32'h24);
`else
        for (int i = 0; i < 20; i++) begin
            settle();
            check("nowdog.fetch_fault", 32'(fetch_fault), 32'h0);
            check("nowdog.fault_cause", 32'(fault_cause), 32'h0);
            check("nowdog.instr_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0077;
        tick();
        imem_rsp_valid = 1'b0;
        settle();
        check("nowdog.rsp_valid", 32'(instr_valid), 32'h1);
        check("nowdog.rsp_instr", instr,            32'h0000_0077);
        check("nowdog.rsp_pc",    instr_pc,         32'h20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
